// File: rtl/hazard_stall_ctrl_if.sv
// Interface bundling the ID/EX/MEM hazard inputs and the stall/MD controls of hazard_stall_ctrl.
// master drives the pipeline fields; slave is the stall controller itself.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_md_op;
  logic             id_hilo_rd;
  logic             ex_wreg;
  logic             ex_m2reg;
  logic [4:0]       ex_rn;
  logic             mem_wreg;
  logic [4:0]       mem_rn;
  logic             stall;
  logic             bubble;
  logic             md_start;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_md_op, id_hilo_rd,
    output ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_rn,
    input  stall, bubble, md_start, md_busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_op, id_hilo_rd,
    input  ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_rn,
    output stall, bubble, md_start, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ID-stage stall/bubble generator with MD busy sequencer and stall-cycle counter.
// Define FORWARD_EN when the EX/MEM forwarding paths exist (only load-use then stalls).
module hazard_stall_ctrl #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               clrn,
  hazard_stall_ctrl_if.slave hz
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t        state, state_nxt;
  logic [7:0]       md_cnt, md_cnt_nxt;
  logic             raw_ex, raw_mem, data_stall, md_hz;
  logic             stall_i, start_i;
  logic [CNT_W-1:0] stall_cnt_q;

  // Register 0 is hardwired, so a destination of r0 never produces a dependency.
  always_comb begin
    raw_ex  = hz.ex_wreg & (hz.ex_rn != 5'd0) &
              ((hz.id_use_rs & (hz.ex_rn == hz.id_rs)) |
               (hz.id_use_rt & (hz.ex_rn == hz.id_rt)));
    raw_mem = hz.mem_wreg & (hz.mem_rn != 5'd0) &
              ((hz.id_use_rs & (hz.mem_rn == hz.id_rs)) |
               (hz.id_use_rt & (hz.mem_rn == hz.id_rt)));
  end

`ifdef FORWARD_EN
  assign data_stall = raw_ex & hz.ex_m2reg;
`else
  assign data_stall = raw_ex | raw_mem;
`endif

  assign md_hz   = (hz.id_md_op | hz.id_hilo_rd) & (state != IDLE);
  assign stall_i = clrn & (data_stall | md_hz);

  // A stalled MD op stays in ID and simply retries, so start needs no memory.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    start_i    = 1'b0;
    case (state)
      IDLE: begin
        if (clrn & hz.id_md_op & ~stall_i) begin
          start_i    = 1'b1;
          md_cnt_nxt = 8'(MD_CYCLES - 1);
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        if (md_cnt == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          md_cnt_nxt = md_cnt - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      md_cnt      <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (stall_i) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.stall     = stall_i;
  assign hz.bubble    = stall_i;
  assign hz.md_start  = start_i;
  assign hz.md_busy   = (state != IDLE);
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl (MD_CYCLES=4, CNT_W=4); honours FORWARD_EN when defined.
module tb_hazard_stall_ctrl;
  localparam int MDC = 4;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic clrn;

  hazard_stall_ctrl_if #(.CNT_W(CW)) hz ();
  hazard_stall_ctrl #(.MD_CYCLES(MDC), .CNT_W(CW)) dut (.clk(clk), .clrn(clrn), .hz(hz));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs; logic [4:0] rt; logic use_rs; logic use_rt;
    logic md_op; logic hilo_rd; logic ex_wreg; logic ex_m2reg;
    logic [4:0] ex_rn; logic mem_wreg; logic [4:0] mem_rn;
  } vec_t;

  typedef struct packed {
    logic stall; logic bubble; logic md_start; logic md_busy; logic [CW-1:0] cnt;
  } out_t;

  out_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   m_busy_left = 0;
  int   m_cnt = 0;
  logic m_stall = 1'b0;
  logic m_start = 1'b0;
  out_t exp, obs;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                              input logic urt, input logic md, input logic hl, input logic ew,
                              input logic em, input logic [4:0] ern, input logic mw,
                              input logic [4:0] mrn);
    vec_t v;
    v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt; v.md_op = md; v.hilo_rd = hl;
    v.ex_wreg = ew; v.ex_m2reg = em; v.ex_rn = ern; v.mem_wreg = mw; v.mem_rn = mrn;
    return v;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.stall = hz.stall; o.bubble = hz.bubble; o.md_start = hz.md_start;
    o.md_busy = hz.md_busy; o.cnt = hz.stall_cnt;
    return o;
  endfunction

  // Drive one cycle of inputs and push the reference model's prediction.
  task automatic apply(input vec_t v, input logic rst_n);
    logic rex, rmem, dst;
    out_t e;
    clrn = rst_n;
    hz.id_rs = v.rs; hz.id_rt = v.rt; hz.id_use_rs = v.use_rs; hz.id_use_rt = v.use_rt;
    hz.id_md_op = v.md_op; hz.id_hilo_rd = v.hilo_rd; hz.ex_wreg = v.ex_wreg;
    hz.ex_m2reg = v.ex_m2reg; hz.ex_rn = v.ex_rn; hz.mem_wreg = v.mem_wreg; hz.mem_rn = v.mem_rn;
    if (!rst_n) begin
      m_busy_left = 0;
      m_cnt = 0;
    end
    rex  = v.ex_wreg && (v.ex_rn != 0) &&
           ((v.use_rs && v.ex_rn == v.rs) || (v.use_rt && v.ex_rn == v.rt));
    rmem = v.mem_wreg && (v.mem_rn != 0) &&
           ((v.use_rs && v.mem_rn == v.rs) || (v.use_rt && v.mem_rn == v.rt));
`ifdef FORWARD_EN
    dst = rex && v.ex_m2reg;
`else
    dst = rex || rmem;
`endif
    m_stall = rst_n && (dst || ((v.md_op || v.hilo_rd) && m_busy_left > 0));
    m_start = rst_n && v.md_op && !m_stall && (m_busy_left == 0);
    e.stall = m_stall; e.bubble = m_stall; e.md_start = m_start;
    e.md_busy = (m_busy_left > 0); e.cnt = CW'(m_cnt);
    sb.push_back(e);
  endtask

  // Advance the reference model across one rising edge.
  task automatic tick();
    @(posedge clk);
    if (clrn) begin
      if (m_stall) m_cnt = (m_cnt + 1) % (1 << CW);
      if (m_start) m_busy_left = MDC;
      else if (m_busy_left > 0) m_busy_left--;
    end
    #1;
  endtask

  task automatic test_reset();
    vec_t nop, mult, mfhi;
    nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mult = mk(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    mfhi = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    apply(mfhi, 1'b0);
    @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_state: got %b want %b", obs, exp); end
    tick();
    apply(mult, 1'b1);
    @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_mult: got %b want %b", obs, exp); end
    for (int i = 0; i < 2; i++) begin
      tick();
      apply(mfhi, 1'b1);
      @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_busy%0d: got %b want %b", i, obs, exp); end
    end
    tick();
    apply(mfhi, 1'b0);
    @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_abort: got %b want %b", obs, exp); end
    for (int i = 0; i < 3; i++) begin
      tick();
      apply((i == 0) ? mfhi : nop, 1'b1);
      @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_after%0d: got %b want %b", i, obs, exp); end
    end
    tick();
  endtask

  task automatic test_data_hazard();
    vec_t seq [10];
    int   lu_stalls;
    seq[0] = mk(6, 5, 1, 1, 0, 0, 1, 0, 5, 0, 0);
    seq[1] = mk(6, 5, 1, 1, 0, 0, 0, 0, 0, 1, 5);
    seq[2] = mk(6, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    seq[3] = mk(8, 0, 1, 0, 0, 0, 1, 1, 8, 0, 0);
    seq[4] = mk(8, 0, 1, 0, 0, 0, 0, 0, 0, 1, 8);
    seq[5] = mk(8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    seq[6] = mk(0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0);
    seq[7] = mk(3, 5, 1, 1, 0, 0, 1, 0, 9, 1, 5);
    seq[8] = mk(5, 5, 0, 0, 0, 0, 1, 1, 5, 1, 5);
    seq[9] = mk(8, 0, 1, 0, 0, 0, 1, 0, 8, 0, 0);
    lu_stalls = 0;
    for (int i = 0; i < 10; i++) begin
      apply(seq[i], 1'b1);
      @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL data_hz%0d: got %b want %b", i, obs, exp); end
      if ((i == 3 || i == 4) && hz.stall === 1'b1) lu_stalls++;
      tick();
    end
    checks++;
`ifdef FORWARD_EN
    if (lu_stalls !== 1) begin errors++; $display("FAIL load_use_len: got %0d want 1", lu_stalls); end
`else
    if (lu_stalls !== 2) begin errors++; $display("FAIL load_use_len: got %0d want 2", lu_stalls); end
`endif
  endtask

  task automatic test_md_seq();
    vec_t mult, mfhi;
    int   stalls;
    logic issued;
    mult = mk(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    mfhi = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    apply(mult, 1'b1);
    @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL md_start: got %b want %b", obs, exp); end
    tick();
    stalls = 0;
    issued = 1'b0;
    for (int i = 0; i < 20 && !issued; i++) begin
      apply(mfhi, 1'b1);
      @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL md_mfhi%0d: got %b want %b", i, obs, exp); end
      if (hz.stall === 1'b1) stalls++;
      else issued = 1'b1;
      tick();
    end
    checks++;
    if (stalls !== MDC || !issued) begin
      errors++; $display("FAIL md_stall_len: got %0d issued=%b want %0d", stalls, issued, MDC);
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL md_idle: got %b want %b", obs, exp); end
    tick();
  endtask

  task automatic test_start_suppress();
    logic held;
    int   starts, start_at;
    vec_t v;
    held = 1'b1;
    starts = 0;
    start_at = -1;
    for (int i = 0; i < 8; i++) begin
      v = mk(8, 0, held, 1'b0, held, 0, (i == 0), (i == 0), (i == 0) ? 5'd8 : 5'd0,
             (i == 1), (i == 1) ? 5'd8 : 5'd0);
      apply(v, 1'b1);
      @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL suppress%0d: got %b want %b", i, obs, exp); end
      if (hz.md_start === 1'b1) begin starts++; start_at = i; end
      if (!m_stall) held = 1'b0;
      tick();
    end
    checks++;
`ifdef FORWARD_EN
    if (starts !== 1 || start_at !== 1) begin
      errors++; $display("FAIL single_start: got %0d at %0d want 1 at 1", starts, start_at);
    end
`else
    if (starts !== 1 || start_at !== 2) begin
      errors++; $display("FAIL single_start: got %0d at %0d want 1 at 2", starts, start_at);
    end
`endif
  endtask

  task automatic test_back_to_back();
    vec_t mult;
    int   waits;
    logic started;
    mult = mk(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    apply(mult, 1'b1);
    @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL b2b_first: got %b want %b", obs, exp); end
    tick();
    waits = 0;
    started = 1'b0;
    for (int i = 0; i < 20 && !started; i++) begin
      apply(mult, 1'b1);
      @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL b2b%0d: got %b want %b", i, obs, exp); end
      if (hz.md_start === 1'b1) started = 1'b1;
      else waits++;
      tick();
    end
    checks++;
    if (waits !== MDC || !started) begin
      errors++; $display("FAIL b2b_wait: got %0d started=%b want %0d", waits, started, MDC);
    end
  endtask

  task automatic test_wrap();
    vec_t lu;
    lu = mk(8, 0, 1, 0, 0, 0, 1, 1, 8, 0, 0);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL wrap_reset: got %b want %b", obs, exp); end
    tick();
    for (int i = 0; i < 17; i++) begin
      apply(lu, 1'b1);
      @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL wrap%0d: got %b want %b", i, obs, exp); end
      tick();
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    @(negedge clk); exp = sb.pop_front(); obs = observe(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL wrap_end: got %b want %b", obs, exp); end
    checks++;
    if (hz.stall_cnt !== 4'd1) begin
      errors++; $display("FAIL wrap_value: got %0d want 1", hz.stall_cnt);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_data_hazard();
    test_md_seq();
    test_start_suppress();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
